seq_multiplier_sm: RTL and testbench
====================================

Name: seq_multiplier_sm

Overview:
- Parametrised sequential shift-add multiplier, one partial product per clock.
- Successor to the existing 4-bit start/done multiplier. Adds:
  - runtime signed/unsigned mode,
  - busy indication,
  - asynchronous reset,
  - deterministic latency,
  - optional early exit.
- Sits beside the ALU as a multi-cycle functional unit. The controller issues start and waits for done.

Parameters:
- WIDTH, 8, operand width in bits (>=2); result is 2*WIDTH.
- EARLY_EXIT, 0, when 1, iteration stops as soon as the remaining multiplier bits are all zero.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- a  in  WIDTH  multiplicand; sampled with start.
- b  in  WIDTH  multiplier; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; res is valid in that cycle.
- res  out  2*WIDTH  product; held until the next completion or reset.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, busy=0, done=0, res=0, all internal registers cleared.
- Reset mid-operation aborts the operation. No done is produced.
- States: IDLE, RUN, FINAL. busy=1 in RUN and FINAL.
- IDLE, start=1 at an edge:
  - a_reg (2*WIDTH) <= zero-extended |a| (signed mode), else a.
  - b_reg (WIDTH) <= |b| (signed), else b.
  - neg <= is_signed & (a[MSB] ^ b[MSB]).
  - acc <= 0, cnt <= 0, state <= RUN.
- Magnitude: |x| = -x if x[MSB]=1, computed in WIDTH bits as unsigned. |-2^(WIDTH-1)| = 2^(WIDTH-1) is exact.
- RUN, each edge:
  - If b_reg[0], acc <= acc + a_reg (2*WIDTH bits, no overflow possible).
  - a_reg <<= 1, b_reg >>= 1, cnt++.
  - state <= FINAL when cnt==WIDTH-1, or (EARLY_EXIT and the shifted b_reg==0).
- FINAL edge: res <= neg ? -acc : acc (2*WIDTH two's complement), done <= 1, state <= IDLE.
- done clears at the following edge. start may be accepted in the done cycle (back-to-back).
- Latency: the edge sampling start is edge 0.
  - EARLY_EXIT=0: done is high after edge WIDTH+1, fixed.
  - EARLY_EXIT=1: done is high after edge k+1, where k = max(1, index of the highest set bit of |b| + 1).
- Throughput (EARLY_EXIT=0): one result per WIDTH+2 cycles.
- start while busy=1 is ignored. Operand and mode changes during busy have no effect.
- is_signed=0 with MSB set: the operand is treated as a large unsigned value, with no sign correction.
- Zero operand: result 0, neg irrelevant; -0 = 0.
- No X on outputs after reset. res is never updated except in FINAL.

Decomposition:
- Shared package holds:
  - state encoding localparams (IDLE=2'b00, RUN=2'b01, FINAL=2'b10),
  - counter width function clog2(WIDTH).
- One sub-module: mult_shift_add_dp, the datapath (a_reg, b_reg, acc, add/shift, final conditional negate).
  - Controlled by load/step/finish strobes from the FSM in seq_multiplier_sm.

Test Plan:
- WIDTH=4, EARLY_EXIT=0, unsigned a=15, b=15, start one cycle -> done after edge 5, res=8'hE1 (225), busy high for 5 cycles.
- WIDTH=4, signed a=4'b1000 (-8), b=4'b1000 (-8) -> res=8'h40 (64). Signed a=-3 (4'hD), b=5 -> res=8'hF1 (-15).
- WIDTH=4, unsigned a=4'hD, b=5 -> res=8'h41 (65). Same bits, signed -> res=8'hF1, verifying mode switch.
- start re-asserted with a=1, b=1 while busy -> ignored; first result unchanged. start in the done cycle -> accepted, second done exactly WIDTH+2 cycles after the first.
- reset_n low at edge 2 of an operation -> busy=0, done=0, res=0 immediately (asynchronous). No done pulse follows. A new operation completes correctly.
- WIDTH=8, EARLY_EXIT=1, unsigned a=200, b=1 -> done after edge 2, res=200. b=0 -> done after edge 2, res=0. b=8'h80 -> done after edge 9, res=25600.

Source files
------------

// File: rtl/seq_multiplier_sm_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
//   state_e : controller state encoding (IDLE / RUN / FINAL)
//   clog2   : bits needed to count 0 .. value-1
package seq_multiplier_sm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FINAL = 2'b10
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier_sm_if.sv
// Request/response bundle between the controller and the multiplier.
//   master : drives start, is_signed, a, b; observes busy, done, res
//   slave  : the multiplier side
interface seq_multiplier_sm_if #(
  parameter int unsigned WIDTH = 8
);

  logic                   start;
  logic                   is_signed;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     res;

  modport master (output start, is_signed, a, b, input busy, done, res);
  modport slave  (input start, is_signed, a, b, output busy, done, res);

endinterface

// File: rtl/seq_multiplier_sm_dp.sv
// Shift-add datapath for seq_multiplier_sm.
//   clk, reset_n      : clock, async active-low reset
//   load              : capture operand magnitudes and result sign, clear acc
//   step              : one partial product: conditional add, shift a/b
//   finish            : write the sign-corrected accumulator to res
//   is_signed, a, b   : operands (used only with load)
//   b_rest_zero       : multiplier bits remaining after this step are all zero
//   res               : product, held between finishes
module mult_shift_add_dp #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic               step,
  input  logic               finish,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               b_rest_zero,
  output logic [2*WIDTH-1:0] res
);

  logic [2*WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   b_shift;

  always_comb begin
    // Magnitude in WIDTH bits unsigned: the most negative value maps exactly.
    a_mag       = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag       = (is_signed && b[WIDTH-1]) ? -b : b;
    b_shift     = b_q >> 1;
    b_rest_zero = (b_shift == '0);

    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    neg_d = neg_q;
    res_d = res_q;

    if (load) begin
      a_d   = {{WIDTH{1'b0}}, a_mag};
      b_d   = b_mag;
      acc_d = '0;
      neg_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      if (b_q[0]) acc_d = acc_q + a_q;
      a_d = a_q << 1;
      b_d = b_shift;
    end

    if (finish) res_d = neg_q ? -acc_q : acc_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      neg_q <= 1'b0;
      res_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      neg_q <= neg_d;
      res_q <= res_d;
    end
  end

  assign res = res_q;

endmodule

// File: rtl/seq_multiplier_sm.sv
// Sequential shift-add multiplier, one partial product per clock.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset, aborts any operation
//   bus      : start/is_signed/a/b in, busy/done/res out (slave side)
// Parameters: WIDTH operand width (>=2), EARLY_EXIT stop once the remaining
// multiplier bits are zero.
module seq_multiplier_sm
  import seq_multiplier_sm_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          EARLY_EXIT = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  seq_multiplier_sm_if.slave bus
);

  localparam int unsigned CNT_W = clog2(WIDTH);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               load;
  logic               step;
  logic               finish;
  logic               b_rest_zero;
  logic [2*WIDTH-1:0] res;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1) || (EARLY_EXIT && b_rest_zero))
          state_d = FINAL;
      end
      FINAL: begin
        finish  = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // busy/done registered from the next state so they align with state_q.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  mult_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .step        (step),
    .finish      (finish),
    .is_signed   (bus.is_signed),
    .a           (bus.a),
    .b           (bus.b),
    .b_rest_zero (b_rest_zero),
    .res         (res)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.res  = res;

endmodule

// File: tb/tb_seq_multiplier_sm.sv
module tb_seq_multiplier_sm;

  logic clk;
  logic rst4_n;
  logic rst8_n;

  int   n_chk;
  int   n_pass;

  logic [7:0]  prev4;
  logic [15:0] prev8;
  time         t_done4;

  seq_multiplier_sm_if #(.WIDTH(4)) m4 ();
  seq_multiplier_sm_if #(.WIDTH(8)) m8 ();

  seq_multiplier_sm #(.WIDTH(4), .EARLY_EXIT(1'b0)) dut4 (
    .clk     (clk),
    .reset_n (rst4_n),
    .bus     (m4)
  );

  seq_multiplier_sm #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut8 (
    .clk     (clk),
    .reset_n (rst8_n),
    .bus     (m8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: plain integer product of the operands as interpreted by mode.
  function automatic int sval(input int unsigned raw, input int w, input logic sg);
    if (sg && raw >= (1 << (w - 1))) return int'(raw) - (1 << w);
    return int'(raw);
  endfunction

  function automatic logic [7:0] ref4(input logic sg, input logic [3:0] a, input logic [3:0] b);
    int p;
    p = sval(a, 4, sg) * sval(b, 4, sg);
    return 8'(p);
  endfunction

  function automatic logic [15:0] ref8(input logic sg, input logic [7:0] a, input logic [7:0] b);
    int p;
    p = sval(a, 8, sg) * sval(b, 8, sg);
    return 16'(p);
  endfunction

  // Early-exit latency: k = max(1, highest set bit of |b| + 1), done after edge k+1.
  function automatic int lat8(input logic sg, input logic [7:0] b);
    int mag;
    int k;
    mag = sval(b, 8, sg);
    if (mag < 0) mag = -mag;
    k = 1;
    for (int i = 0; i < 8; i++) if ((mag >> i) & 1) k = i + 1;
    return k + 1;
  endfunction

  // Called #1 after a posedge; returns #1 after the done edge.
  task automatic op4(input logic sg, input logic [3:0] a, input logic [3:0] b, input bit poke);
    logic [7:0] exp;
    int lat;
    int bcyc;
    bit hold_ok;
    exp = ref4(sg, a, b);
    m4.start = 1'b1; m4.is_signed = sg; m4.a = a; m4.b = b;
    @(posedge clk); #1;
    m4.start = 1'b0; m4.is_signed = 1'($urandom); m4.a = 4'($urandom); m4.b = 4'($urandom);
    lat = 0; bcyc = 0; hold_ok = 1'b1;
    while (m4.done !== 1'b1 && lat < 40) begin
      if (m4.busy === 1'b1) bcyc++;
      if (m4.res !== prev4) hold_ok = 1'b0;
      if (poke && lat == 1) begin m4.start = 1'b1; m4.a = 4'd1; m4.b = 4'd1; end
      if (poke && lat == 2) m4.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    t_done4 = $time;
    chk("w4_latency", 64'(lat), 64'd5);
    chk("w4_res", 64'(m4.res), 64'(exp));
    chk("w4_busy_cycles", 64'(bcyc), 64'd5);
    chk("w4_busy_at_done", 64'(m4.busy), 64'd0);
    chk("w4_res_held", 64'(hold_ok), 64'd1);
    prev4 = exp;
  endtask

  task automatic op8(input logic sg, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] exp;
    int lat;
    bit hold_ok;
    exp = ref8(sg, a, b);
    m8.start = 1'b1; m8.is_signed = sg; m8.a = a; m8.b = b;
    @(posedge clk); #1;
    m8.start = 1'b0; m8.is_signed = 1'($urandom); m8.a = 8'($urandom); m8.b = 8'($urandom);
    lat = 0; hold_ok = 1'b1;
    while (m8.done !== 1'b1 && lat < 40) begin
      if (m8.res !== prev8) hold_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("w8_latency", 64'(lat), 64'(lat8(sg, b)));
    chk("w8_res", 64'(m8.res), 64'(exp));
    chk("w8_res_held", 64'(hold_ok), 64'd1);
    @(posedge clk); #1;
    chk("w8_done_pulse", 64'(m8.done), 64'd0);
    prev8 = exp;
  endtask

  initial begin
    time t1;
    bit  saw_done;
    n_chk = 0; n_pass = 0;
    prev4 = '0; prev8 = '0; t_done4 = 0;
    rst4_n = 1'b0; rst8_n = 1'b0;
    m4.start = 1'b0; m4.is_signed = 1'b0; m4.a = '0; m4.b = '0;
    m8.start = 1'b0; m8.is_signed = 1'b0; m8.a = '0; m8.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst4_busy", 64'(m4.busy), 64'd0);
    chk("rst4_done", 64'(m4.done), 64'd0);
    chk("rst4_res", 64'(m4.res), 64'd0);
    chk("rst8_res", 64'(m8.res), 64'd0);
    @(negedge clk);
    rst4_n = 1'b1; rst8_n = 1'b1;
    @(posedge clk); #1;

    // Directed WIDTH=4 vectors, including ignored start while busy.
    op4(1'b0, 4'hF, 4'hF, 1'b1);
    op4(1'b1, 4'h8, 4'h8, 1'b0);
    op4(1'b1, 4'hD, 4'h5, 1'b0);
    op4(1'b0, 4'hD, 4'h5, 1'b0);
    op4(1'b1, 4'hD, 4'h5, 1'b0);

    // Back-to-back: start in the done cycle.
    t1 = t_done4;
    op4(1'b0, 4'h7, 4'h9, 1'b0);
    chk("w4_b2b_gap", 64'((t_done4 - t1) / 10), 64'd6);

    // Asynchronous reset mid-operation.
    op4(1'b0, 4'hF, 4'hF, 1'b0);
    m4.start = 1'b1; m4.a = 4'h7; m4.b = 4'h3; m4.is_signed = 1'b0;
    @(posedge clk); #1;
    m4.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst4_n = 1'b0;
    #1;
    chk("rst_mid_busy", 64'(m4.busy), 64'd0);
    chk("rst_mid_done", 64'(m4.done), 64'd0);
    chk("rst_mid_res", 64'(m4.res), 64'd0);
    @(negedge clk);
    rst4_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (m4.done === 1'b1) saw_done = 1'b1;
    end
    chk("rst_no_done", 64'(saw_done), 64'd0);
    prev4 = '0;
    op4(1'b1, 4'h9, 4'h6, 1'b0);

    // Random WIDTH=4 with random idle gaps (zero gap = back-to-back).
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      op4(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
    end

    // Directed WIDTH=8 early-exit vectors.
    op8(1'b0, 8'd200, 8'd1);
    op8(1'b0, 8'd200, 8'd0);
    op8(1'b0, 8'd200, 8'h80);
    op8(1'b1, 8'h80, 8'h80);
    op8(1'b1, 8'h80, 8'hFF);

    for (int i = 0; i < 25; i++) begin
      logic [7:0] rb;
      rb = 8'($urandom) >> $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) rb = '0;
      op8(1'($urandom), 8'($urandom), rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
